// File: rtl/noc_network_interface_pkg.sv
// Shared NoC types: packet layout, bus beat and packet-type constants for the ring-stop NIU.
package noc_network_interface_pkg;

    localparam int unsigned NOC_BYTES = 32;
    localparam int unsigned NOC_BITS  = NOC_BYTES * 8;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned BP_W      = 6;
    localparam int unsigned HDR_BITS  = 24;

    typedef enum logic [7:0] {
        MEMORY_READ_REQUEST  = 8'h00,
        MEMORY_WRITE_REQUEST = 8'h01,
        MEMORY_READ_REPLY    = 8'h02,
        MEMORY_WRITE_REPLY   = 8'h03
    } noc_packet_type_e;

    typedef struct packed {
        logic [7:0]        len;
        logic [ADDR_W-1:0] src_port;
        logic [ADDR_W-1:0] src_addr;
        logic [ADDR_W-1:0] dst_port;
        logic [ADDR_W-1:0] dst_addr;
    } noc_packet_header;

    typedef struct packed {
        logic [NOC_BITS-HDR_BITS-1:0] dat;
        noc_packet_header             hdr;
    } noc_packet;

    typedef logic [NOC_BYTES-1:0][7:0] noc_bus_t;

    // Zero every byte at or above the bytes-present count.
    function automatic noc_bus_t mask_bytes(input noc_bus_t d, input logic [BP_W-1:0] bp);
        noc_bus_t m;
        for (int k = 0; k < int'(NOC_BYTES); k++) begin
            m[k] = (k < int'(bp)) ? d[k] : 8'h00;
        end
        return m;
    endfunction

    function automatic logic len_ok(input logic [7:0] len);
        return (len != 8'd0) && (len <= 8'(NOC_BYTES));
    endfunction

    function automatic logic [BP_W-1:0] bp_of_len(input logic [7:0] len);
        return (len > 8'(NOC_BYTES)) ? BP_W'(NOC_BYTES) : BP_W'(len);
    endfunction

endpackage

// File: rtl/noc_network_interface_if.sv
// Client-port and ring-bus signal bundle; master is the NIU side, slave the clients/ring.
interface noc_network_interface_if
    import noc_network_interface_pkg::*;
#(
    parameter int unsigned PORTS = 1
);
    logic [PORTS-1:0][ADDR_W-1:0] prt_addr;
    logic [PORTS-1:0][ADDR_W-1:0] prt_num;
    logic [PORTS-1:0]             rx_av;
    logic [PORTS-1:0]             rx_re;
    noc_packet [PORTS-1:0]        rx_dat;
    logic [PORTS-1:0]             tx_av;
    logic [PORTS-1:0]             tx_re;
    noc_packet [PORTS-1:0]        tx_dat;
    noc_bus_t                     bus_inp_dat;
    logic [BP_W-1:0]              bus_inp_bp;
    logic                         bus_inp_bo;
    noc_bus_t                     bus_oup_dat;
    logic [BP_W-1:0]              bus_oup_bp;
    logic                         bus_oup_bo;

    modport master (
        output prt_addr, prt_num, rx_av, rx_dat, tx_re, bus_inp_bo, bus_oup_dat, bus_oup_bp,
        input  rx_re, tx_av, tx_dat, bus_inp_dat, bus_inp_bp, bus_oup_bo
    );

    modport slave (
        input  prt_addr, prt_num, rx_av, rx_dat, tx_re, bus_inp_bo, bus_oup_dat, bus_oup_bp,
        output rx_re, tx_av, tx_dat, bus_inp_dat, bus_inp_bp, bus_oup_bo
    );
endinterface

// File: rtl/noc_network_interface_slot.sv
// One-entry packet holding register; push wins over pop (callers never assert both).
module niu_port_slot
    import noc_network_interface_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  noc_packet i_dat,
    output logic      o_valid,
    output noc_packet o_dat
);
    logic      r_valid;
    noc_packet r_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_dat   <= '0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_dat   <= i_dat;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_dat   = r_dat;
endmodule

// File: rtl/noc_network_interface.sv
// Ring-stop NIU: delivers local packets to RX slots, forwards the rest, merges client TX traffic.
module noc_network_interface
    import noc_network_interface_pkg::*;
#(
    parameter int unsigned       PORTS     = 1,
    parameter logic [ADDR_W-1:0] NODE_ADDR = 4'd0
) (
    input  logic                    fclk,
    input  logic                    rst,
    noc_network_interface_if.master nif
);
    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic                 r_run;
    logic [BP_W-1:0]      r_oup_bp;
    noc_packet            r_oup_pkt;
    logic [PW-1:0]        r_last;

    noc_packet            w_inp_pkt;
    logic                 w_inp_bo;
    logic                 w_inp_take;
    logic                 w_is_local;
    logic                 w_fwd_valid;
    logic                 w_fwd_pop;
    noc_packet            w_fwd_dat;
    logic [PORTS-1:0]     w_rx_valid;
    logic [PORTS-1:0]     w_rx_push;
    logic [PORTS-1:0]     w_rx_pop;
    noc_packet [PORTS-1:0] w_rx_dat;
    logic [PORTS-1:0]     w_tx_valid;
    logic [PORTS-1:0]     w_tx_re;
    logic [PORTS-1:0]     w_tx_push;
    logic [PORTS-1:0]     w_tx_pop;
    noc_packet [PORTS-1:0] w_tx_dat;
    logic                 w_load;
    logic                 w_tx_hit;
    logic [PW-1:0]        w_tx_sel;
    int unsigned          w_idx;

    // r_run keeps bo/tx_re low while reset is held and for the release edge.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) r_run <= 1'b0;
        else     r_run <= 1'b1;
    end

    assign w_inp_bo   = r_run && !w_fwd_valid && (w_rx_valid == '0);
    assign w_inp_take = (nif.bus_inp_bp != '0) && w_inp_bo;
    assign w_inp_pkt  = noc_packet'(mask_bytes(nif.bus_inp_dat, nif.bus_inp_bp));
    assign w_is_local = (w_inp_pkt.hdr.dst_addr == NODE_ADDR);
    assign w_tx_re    = {PORTS{r_run}} & ~w_tx_valid;

    niu_port_slot u_fwd (
        .clk    (fclk),
        .rst    (rst),
        .i_push (w_inp_take && !w_is_local),
        .i_pop  (w_fwd_pop),
        .i_dat  (w_inp_pkt),
        .o_valid(w_fwd_valid),
        .o_dat  (w_fwd_dat)
    );

    for (genvar i = 0; i < int'(PORTS); i++) begin : g_port
        // Local packets whose port number matches no slot simply never push.
        assign w_rx_push[i] = w_inp_take && w_is_local && (w_inp_pkt.hdr.dst_port == ADDR_W'(i));
        assign w_rx_pop[i]  = nif.rx_re[i] && w_rx_valid[i];
        assign w_tx_push[i] = nif.tx_av[i] && w_tx_re[i] && len_ok(nif.tx_dat[i].hdr.len);

        niu_port_slot u_rx (
            .clk    (fclk),
            .rst    (rst),
            .i_push (w_rx_push[i]),
            .i_pop  (w_rx_pop[i]),
            .i_dat  (w_inp_pkt),
            .o_valid(w_rx_valid[i]),
            .o_dat  (w_rx_dat[i])
        );

        niu_port_slot u_tx (
            .clk    (fclk),
            .rst    (rst),
            .i_push (w_tx_push[i]),
            .i_pop  (w_tx_pop[i]),
            .i_dat  (nif.tx_dat[i]),
            .o_valid(w_tx_valid[i]),
            .o_dat  (w_tx_dat[i])
        );

        assign nif.prt_addr[i] = NODE_ADDR;
        assign nif.prt_num[i]  = ADDR_W'(i);
    end

    // Output arbitration: forward slot first, then TX round-robin after the last grant.
    always_comb begin
        w_load    = (r_oup_bp == '0) || nif.bus_oup_bo;
        w_fwd_pop = w_load && w_fwd_valid;
        w_tx_hit  = 1'b0;
        w_tx_sel  = r_last;
        w_tx_pop  = '0;
        w_idx     = 0;
        if (w_load && !w_fwd_valid) begin
            for (int k = 1; k <= int'(PORTS); k++) begin
                w_idx = (32'(r_last) + 32'(k)) % PORTS;
                if (!w_tx_hit && w_tx_valid[w_idx]) begin
                    w_tx_hit = 1'b1;
                    w_tx_sel = PW'(w_idx);
                end
            end
        end
        for (int k = 0; k < int'(PORTS); k++) begin
            w_tx_pop[k] = w_tx_hit && (w_tx_sel == PW'(k));
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_oup_bp  <= '0;
            r_oup_pkt <= '0;
            r_last    <= PW'(PORTS - 1);
        end else if (w_load) begin
            if (w_fwd_valid) begin
                r_oup_bp  <= bp_of_len(w_fwd_dat.hdr.len);
                r_oup_pkt <= w_fwd_dat;
            end else if (w_tx_hit) begin
                r_oup_bp  <= bp_of_len(w_tx_dat[w_tx_sel].hdr.len);
                r_oup_pkt <= w_tx_dat[w_tx_sel];
                r_last    <= w_tx_sel;
            end else begin
                r_oup_bp  <= '0;
                r_oup_pkt <= '0;
            end
        end
    end

    assign nif.rx_av       = w_rx_valid;
    assign nif.rx_dat      = w_rx_dat;
    assign nif.tx_re       = w_tx_re;
    assign nif.bus_inp_bo  = w_inp_bo;
    assign nif.bus_oup_bp  = r_oup_bp;
    assign nif.bus_oup_dat = noc_bus_t'(r_oup_pkt);
endmodule

// File: tb/tb_noc_network_interface.sv
// Directed bench for the ring-stop NIU with a transaction-level occupancy model checked every cycle.
module tb_noc_network_interface;
    import noc_network_interface_pkg::*;

    localparam int unsigned PORTS = 2;
    localparam logic [3:0]  NODE  = 4'd0;

    logic fclk = 1'b0;
    logic rst  = 1'b1;
    always #5 fclk = ~fclk;

    noc_network_interface_if #(.PORTS(PORTS)) nif ();

    noc_network_interface #(.PORTS(PORTS), .NODE_ADDR(NODE)) dut (
        .fclk(fclk),
        .rst (rst),
        .nif (nif)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    function automatic logic [255:0] mk(input logic [3:0] da, input logic [3:0] dp,
                                        input logic [7:0] len, input logic [7:0] typ,
                                        input logic [7:0] seed);
        logic [255:0] p;
        for (int k = 4; k < 32; k++) p[8*k +: 8] = seed + 8'(k);
        p[7:0]   = {dp, da};
        p[15:8]  = 8'h31;
        p[23:16] = len;
        p[31:24] = typ;
        return p;
    endfunction

    function automatic logic [255:0] trunc(input logic [255:0] d, input int nbytes);
        logic [255:0] m;
        for (int k = 0; k < 32; k++) m[8*k +: 8] = (k < nbytes) ? d[8*k +: 8] : 8'h00;
        return m;
    endfunction

    // ---------------- behavioural model ----------------
    logic         m_run = 1'b0;
    logic         m_fwd_v = 1'b0;
    logic [255:0] m_fwd = '0;
    logic         m_rx_v [PORTS] = '{default: 1'b0};
    logic [255:0] m_rx   [PORTS] = '{default: '0};
    logic         m_tx_v [PORTS] = '{default: 1'b0};
    logic [255:0] m_tx   [PORTS] = '{default: '0};
    int           m_out_bp = 0;
    logic [255:0] m_out = '0;
    int           m_last = PORTS - 1;

    function automatic logic model_bo();
        logic any_rx = 1'b0;
        for (int p = 0; p < PORTS; p++) any_rx |= m_rx_v[p];
        return m_run && !m_fwd_v && !any_rx;
    endfunction

    function automatic int len_to_bp(input logic [255:0] p);
        int l = int'(p[23:16]);
        return (l > 32) ? 32 : l;
    endfunction

    logic         s_bo;
    logic         s_tx_re [PORTS];
    logic [255:0] s_beat;
    logic         s_found;
    int           s_p;

    always @(posedge fclk or posedge rst) begin
        if (rst) begin
            m_run = 1'b0; m_fwd_v = 1'b0; m_out_bp = 0; m_out = '0; m_last = PORTS - 1;
            for (int p = 0; p < PORTS; p++) begin
                m_rx_v[p] = 1'b0; m_rx[p] = '0; m_tx_v[p] = 1'b0;
            end
        end else begin
            s_bo = model_bo();
            for (int p = 0; p < PORTS; p++) s_tx_re[p] = m_run && !m_tx_v[p];
            // output stage sees slot contents from before this edge
            if (m_out_bp == 0 || nif.bus_oup_bo) begin
                s_found = 1'b0;
                if (m_fwd_v) begin
                    m_out = m_fwd; m_out_bp = len_to_bp(m_fwd); m_fwd_v = 1'b0; s_found = 1'b1;
                end else begin
                    for (int k = 1; k <= PORTS; k++) begin
                        s_p = (m_last + k) % PORTS;
                        if (!s_found && m_tx_v[s_p]) begin
                            s_found = 1'b1; m_out = m_tx[s_p]; m_out_bp = len_to_bp(m_tx[s_p]);
                            m_tx_v[s_p] = 1'b0; m_last = s_p;
                        end
                    end
                end
                if (!s_found) begin m_out_bp = 0; m_out = '0; end
            end
            for (int p = 0; p < PORTS; p++) begin
                if (nif.rx_re[p] && m_rx_v[p]) m_rx_v[p] = 1'b0;
                if (nif.tx_av[p] && s_tx_re[p] && nif.tx_dat[p][23:16] != 0 && nif.tx_dat[p][23:16] <= 32) begin
                    m_tx_v[p] = 1'b1; m_tx[p] = nif.tx_dat[p];
                end
            end
            if (nif.bus_inp_bp != 0 && s_bo) begin
                s_beat = trunc(nif.bus_inp_dat, int'(nif.bus_inp_bp));
                if (s_beat[3:0] != NODE) begin
                    m_fwd_v = 1'b1; m_fwd = s_beat;
                end else if (int'(s_beat[7:4]) < PORTS) begin
                    m_rx_v[s_beat[7:4]] = 1'b1; m_rx[s_beat[7:4]] = s_beat;
                end
            end
            m_run = 1'b1;
        end
    end

    // compare process: every outputs against the model, away from the active edge
    logic [PORTS-1:0] c_rx_av, c_tx_re;
    always @(negedge fclk) begin
        for (int p = 0; p < PORTS; p++) begin
            c_rx_av[p] = m_rx_v[p];
            c_tx_re[p] = m_run && !m_tx_v[p];
        end
        check("bus_inp_bo", 256'(nif.bus_inp_bo), 256'(model_bo()));
        check("rx_av", 256'(nif.rx_av), 256'(c_rx_av));
        check("tx_re", 256'(nif.tx_re), 256'(c_tx_re));
        check("bus_oup_bp", 256'(nif.bus_oup_bp), 256'(m_out_bp));
        if (m_out_bp != 0) check("bus_oup_dat", nif.bus_oup_dat, m_out);
        for (int p = 0; p < PORTS; p++) begin
            if (m_rx_v[p]) check($sformatf("rx_dat%0d", p), nif.rx_dat[p], m_rx[p]);
            check($sformatf("prt_num%0d", p), 256'(nif.prt_num[p]), 256'(p));
            check($sformatf("prt_addr%0d", p), 256'(nif.prt_addr[p]), 256'(NODE));
        end
    end

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    logic [255:0] pk;

    initial begin
        nif.rx_re = '0; nif.tx_av = '0; nif.tx_dat = '0;
        nif.bus_inp_dat = '0; nif.bus_inp_bp = '0; nif.bus_oup_bo = 1'b0;

        // reset
        repeat (2) tick();
        check("rst_bo", 256'(nif.bus_inp_bo), 256'(0));
        check("rst_tx_re", 256'(nif.tx_re), 256'(0));
        check("rst_oup_dat", nif.bus_oup_dat, 256'(0));
        check("rst_rx_dat0", nif.rx_dat[0], 256'(0));
        rst = 1'b0;
        tick();
        check("post_rst_bo", 256'(nif.bus_inp_bo), 256'(1));
        check("post_rst_tx_re", 256'(nif.tx_re), 256'(2'b11));
        check("post_rst_rx_av", 256'(nif.rx_av), 256'(0));
        check("post_rst_bp", 256'(nif.bus_oup_bp), 256'(0));

        // local RX to port 0, len 24
        nif.bus_inp_dat = mk(4'd0, 4'd0, 8'd24, 8'h02, 8'h10); nif.bus_inp_bp = 6'd24;
        tick();
        nif.bus_inp_bp = '0;
        check("rx0_av", 256'(nif.rx_av), 256'(2'b01));
        check("rx0_bo", 256'(nif.bus_inp_bo), 256'(0));
        pk = nif.rx_dat[0];
        check("rx0_hi_bytes", 256'(pk[255:192]), 256'(0));
        check("rx0_type", 256'(pk[31:24]), 256'(8'h02));
        check("rx0_byte23", 256'(pk[191:184]), 256'(8'h27));
        nif.rx_re = 2'b01;
        tick();
        nif.rx_re = '0;
        check("rx0_pop_av", 256'(nif.rx_av), 256'(0));
        check("rx0_pop_bo", 256'(nif.bus_inp_bo), 256'(1));

        // short beat to port 1: bp below len truncates
        nif.bus_inp_dat = mk(4'd0, 4'd1, 8'd24, 8'h03, 8'h50); nif.bus_inp_bp = 6'd10;
        tick();
        nif.bus_inp_bp = '0;
        check("rx1_av", 256'(nif.rx_av), 256'(2'b10));
        pk = nif.rx_dat[1];
        check("rx1_trunc", 256'(pk[255:80]), 256'(0));
        check("rx1_byte9", 256'(pk[79:72]), 256'(8'h59));
        nif.rx_re = 2'b11;
        tick();
        nif.rx_re = '0;

        // forward, held while bus_oup_bo low
        nif.bus_inp_dat = mk(4'd5, 4'd1, 8'd20, 8'h01, 8'h40); nif.bus_inp_bp = 6'd20;
        tick();
        nif.bus_inp_bp = '0;
        check("fwd_lat1_bp", 256'(nif.bus_oup_bp), 256'(0));
        tick();
        check("fwd_bp", 256'(nif.bus_oup_bp), 256'(20));
        check("fwd_byte0", 256'(nif.bus_oup_dat[0]), 256'(8'h15));
        check("fwd_byte19", 256'(nif.bus_oup_dat[19]), 256'(8'h53));
        check("fwd_byte20", 256'(nif.bus_oup_dat[20]), 256'(0));
        repeat (2) tick();
        check("fwd_hold_bp", 256'(nif.bus_oup_bp), 256'(20));
        nif.bus_oup_bo = 1'b1;
        tick();
        nif.bus_oup_bo = 1'b0;
        check("fwd_drain_bp", 256'(nif.bus_oup_bp), 256'(0));

        // TX port 0
        nif.tx_dat[0] = noc_packet'(mk(4'd7, 4'd0, 8'd24, 8'h00, 8'h80)); nif.tx_av = 2'b01;
        tick();
        nif.tx_av = '0;
        check("tx_re_busy", 256'(nif.tx_re), 256'(2'b10));
        tick();
        check("tx_bp", 256'(nif.bus_oup_bp), 256'(24));
        nif.bus_oup_bo = 1'b1;
        tick();
        nif.bus_oup_bo = 1'b0;
        check("tx_drain_bp", 256'(nif.bus_oup_bp), 256'(0));
        check("tx_re_free", 256'(nif.tx_re), 256'(2'b11));

        // contention: forward beats TX
        nif.bus_inp_dat = mk(4'd9, 4'd0, 8'd28, 8'h01, 8'h20); nif.bus_inp_bp = 6'd28;
        nif.tx_dat[1] = noc_packet'(mk(4'd3, 4'd2, 8'd16, 8'h00, 8'hA0)); nif.tx_av = 2'b10;
        tick();
        nif.bus_inp_bp = '0; nif.tx_av = '0;
        tick();
        check("cont_first_bp", 256'(nif.bus_oup_bp), 256'(28));
        nif.bus_oup_bo = 1'b1;
        tick();
        check("cont_second_bp", 256'(nif.bus_oup_bp), 256'(16));
        check("cont_second_b0", 256'(nif.bus_oup_dat[0]), 256'(8'h23));
        tick();
        check("cont_idle_bp", 256'(nif.bus_oup_bp), 256'(0));
        nif.bus_oup_bo = 1'b0;

        // round robin: last grant was port 1, so port 0 wins next
        nif.tx_dat[0] = noc_packet'(mk(4'd2, 4'd0, 8'd12, 8'h00, 8'h01));
        nif.tx_dat[1] = noc_packet'(mk(4'd4, 4'd0, 8'd8, 8'h00, 8'h02));
        nif.tx_av = 2'b11;
        tick();
        nif.tx_av = '0;
        tick();
        check("rr_first_bp", 256'(nif.bus_oup_bp), 256'(12));
        nif.bus_oup_bo = 1'b1;
        tick();
        check("rr_second_bp", 256'(nif.bus_oup_bp), 256'(8));
        tick();
        nif.bus_oup_bo = 1'b0;

        // drops: unknown local port, len 0 and len 40 TX
        nif.bus_inp_dat = mk(4'd0, 4'd3, 8'd24, 8'h00, 8'h33); nif.bus_inp_bp = 6'd24;
        tick();
        nif.bus_inp_bp = '0;
        check("drop_rx_av", 256'(nif.rx_av), 256'(0));
        check("drop_bo", 256'(nif.bus_inp_bo), 256'(1));
        nif.tx_dat[0] = noc_packet'(mk(4'd7, 4'd0, 8'd0, 8'h00, 8'h44)); nif.tx_av = 2'b01;
        tick();
        nif.tx_dat[0] = noc_packet'(mk(4'd7, 4'd0, 8'd40, 8'h00, 8'h45));
        check("drop_len0_tx_re", 256'(nif.tx_re), 256'(2'b11));
        tick();
        nif.tx_av = '0;
        check("drop_len40_tx_re", 256'(nif.tx_re), 256'(2'b11));
        repeat (2) tick();
        check("drop_no_out", 256'(nif.bus_oup_bp), 256'(0));

        // reset mid-flight
        nif.bus_inp_dat = mk(4'd6, 4'd0, 8'd16, 8'h01, 8'h60); nif.bus_inp_bp = 6'd16;
        nif.tx_dat[1] = noc_packet'(mk(4'd8, 4'd1, 8'd20, 8'h00, 8'h70)); nif.tx_av = 2'b10;
        tick();
        nif.bus_inp_bp = '0; nif.tx_av = '0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_bp", 256'(nif.bus_oup_bp), 256'(0));
        check("mid_rst_dat", nif.bus_oup_dat, 256'(0));
        check("mid_rst_tx_re", 256'(nif.tx_re), 256'(0));
        check("mid_rst_bo", 256'(nif.bus_inp_bo), 256'(0));
        tick();
        rst = 1'b0;
        tick();
        nif.bus_oup_bo = 1'b1;
        repeat (3) tick();
        check("after_rst_bp", 256'(nif.bus_oup_bp), 256'(0));
        check("after_rst_tx_re", 256'(nif.tx_re), 256'(2'b11));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
